// File: rtl/alu_reg_file.sv
// Register file and carry/zero flag stage feeding an 8-bit ALU; two combinational read ports.
// Optional write-through bypass on the read ports and sc_flag: define ALU_REG_FILE_BYPASS_EN.
module alu_reg_file #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flag_we,
  input  logic          flag_clr,
  input  logic          sc_in,
  input  logic          zero_in,
  output logic          sc_flag,
  output logic          zero_flag,
  output logic [7:0]    wr_count
);

  localparam int NumRegs = 2 ** AW;

  logic [DW-1:0] regs_q [NumRegs];
  logic          sc_q;
  logic          zero_q;
  logic [7:0]    cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      sc_q   <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
        if (cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      // Clear outranks load so a flush can't be masked by a coincident capture.
      if (flag_clr) begin
        sc_q   <= 1'b0;
        zero_q <= 1'b0;
      end else if (flag_we) begin
        sc_q   <= sc_in;
        zero_q <= zero_in;
      end
    end
  end

`ifdef ALU_REG_FILE_BYPASS_EN
  // Bypass is gated by reset so reads still show zero while reset is held.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    sc_flag   = sc_q;
    if (!reset) begin
      if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      if (flag_we && !flag_clr)            sc_flag   = sc_in;
    end
  end
`else
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    sc_flag   = sc_q;
  end
`endif

  assign zero_flag = zero_q;
  assign wr_count  = cnt_q;

endmodule
